// File: rtl/ex_mem_pkg.sv
// Shared types for the EX-to-MEM request path: access-size codes, beat FSM states
// and the size decode helper.
package ex_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2
  } state_t;

  function automatic logic [3:0] size_to_nbytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/ex_mem_req_unit_if.sv
// Op-in / request-out / exception bundle of ex_mem_req_unit.
// slave is the unit's view, master is the EX + memory environment's view.
interface ex_mem_req_unit_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 4
);
  localparam int BUS_BYTES = XLEN / 8;

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_we;
  logic [1:0]           in_size;
  logic                 in_unsigned;
  logic [ADDR_W-1:0]    in_addr;
  logic [XLEN-1:0]      in_wdata;
  logic [TAG_W-1:0]     in_tag;

  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_W-1:0]    req_addr;
  logic                 req_we;
  logic [BUS_BYTES-1:0] req_be;
  logic [XLEN-1:0]      req_wdata;
  logic [2:0]           req_offset;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [TAG_W-1:0]     req_tag;
  logic                 req_last;

  logic                 exc_valid;
  logic [ADDR_W-1:0]    exc_addr;
  logic [TAG_W-1:0]     exc_tag;

  modport slave (
    input  flush, in_valid, in_we, in_size, in_unsigned, in_addr, in_wdata, in_tag, req_ready,
    output in_ready, req_valid, req_addr, req_we, req_be, req_wdata, req_offset, req_size,
           req_unsigned, req_tag, req_last, exc_valid, exc_addr, exc_tag
  );

  modport master (
    output flush, in_valid, in_we, in_size, in_unsigned, in_addr, in_wdata, in_tag, req_ready,
    input  in_ready, req_valid, req_addr, req_we, req_be, req_wdata, req_offset, req_size,
           req_unsigned, req_tag, req_last, exc_valid, exc_addr, exc_tag
  );

endinterface

// File: rtl/ex_mem_lane_align.sv
// Combinational lane steering: builds the two-bus-word byte-enable mask and the
// store data shifted into its byte lanes. Low half is beat 1, high half is beat 2.
module ex_mem_lane_align
  import ex_mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]                  size,
  input  logic [$clog2(XLEN/8)-1:0]   off,
  input  logic [XLEN-1:0]             wdata,
  output logic [2*(XLEN/8)-1:0]       be_wide,
  output logic [2*XLEN-1:0]           wdata_wide
);

  localparam int BEW = 2 * (XLEN / 8);

  logic [BEW-1:0] mask;

  always_comb begin
    mask = '0;
    case (size)
      SZ_B:    mask = BEW'(8'h01);
      SZ_H:    mask = BEW'(8'h03);
      SZ_W:    mask = BEW'(8'h0F);
      SZ_D:    mask = BEW'(8'hFF);
      default: mask = '0;
    endcase
  end

  assign be_wide    = mask << off;
  assign wdata_wide = {{XLEN{1'b0}}, wdata} << {off, 3'b000};

endmodule

// File: rtl/ex_mem_req_unit.sv
// Load/store request generator between EX and the data-memory port; holds one op.
// Define MISALIGN_SPLIT_EN to issue misaligned ops (split in two beats when they cross a bus word).
module ex_mem_req_unit
  import ex_mem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  ex_mem_req_unit_if.slave bus
);

  localparam int BUS_BYTES = XLEN / 8;
  localparam int OFF_W     = $clog2(BUS_BYTES);

  state_t                 state, state_n;
  logic                   load_op;
  logic                   accept, fire, legal, misaligned, bad_size;
  logic [3:0]             nbytes;
  logic [OFF_W-1:0]       off;
  logic [2*BUS_BYTES-1:0] be_wide;
  logic [2*XLEN-1:0]      wdata_wide;
  logic                   exc_q;

  assign off = bus.in_addr[OFF_W-1:0];

  ex_mem_lane_align #(.XLEN(XLEN)) u_align (
    .size       (bus.in_size),
    .off        (off),
    .wdata      (bus.in_wdata),
    .be_wide    (be_wide),
    .wdata_wide (wdata_wide)
  );

  assign nbytes     = size_to_nbytes(bus.in_size);
  assign misaligned = |(bus.in_addr[2:0] & 3'(nbytes - 4'd1));
  assign bad_size   = (XLEN == 32) && (bus.in_size == SZ_D);

`ifdef MISALIGN_SPLIT_EN
  logic                 load_beat2;
  logic                 crosses;
  logic [BUS_BYTES-1:0] be2_q;
  logic [XLEN-1:0]      wdata2_q;

  assign crosses = |be_wide[2*BUS_BYTES-1:BUS_BYTES];
  assign legal   = !bad_size;
`else
  logic unused_hi;

  assign unused_hi = ^{wdata_wide[2*XLEN-1:XLEN], be_wide[2*BUS_BYTES-1:BUS_BYTES]};
  assign legal     = !bad_size && !misaligned;
`endif

  // A new op may enter the same cycle the last beat of the held one retires.
  assign bus.in_ready = (state == IDLE) ||
                        (state == BEAT1 && bus.req_valid && bus.req_ready && bus.req_last);
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  assign fire         = bus.req_valid && bus.req_ready;
  assign bus.exc_valid = exc_q && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load_op = 1'b0;
`ifdef MISALIGN_SPLIT_EN
    load_beat2 = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          load_op = 1'b1;
          state_n = legal ? BEAT1 : IDLE;
        end
      end
      BEAT1: begin
        if (fire) begin
          state_n = IDLE;
          if (accept) begin
            load_op = 1'b1;
            if (legal) state_n = BEAT1;
          end
`ifdef MISALIGN_SPLIT_EN
          if (!bus.req_last) begin
            state_n    = BEAT2;
            load_beat2 = 1'b1;
          end
`endif
        end else if (bus.flush) begin
          state_n = IDLE;
        end
      end
`ifdef MISALIGN_SPLIT_EN
      // Flush is ignored here: the first beat already reached memory.
      BEAT2: begin
        if (fire) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.req_valid    <= 1'b0;
      bus.req_addr     <= '0;
      bus.req_we       <= 1'b0;
      bus.req_be       <= '0;
      bus.req_wdata    <= '0;
      bus.req_offset   <= '0;
      bus.req_size     <= '0;
      bus.req_unsigned <= 1'b0;
      bus.req_tag      <= '0;
      bus.req_last     <= 1'b0;
      bus.exc_addr     <= '0;
      bus.exc_tag      <= '0;
      exc_q            <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      be2_q            <= '0;
      wdata2_q         <= '0;
`endif
    end else begin
      bus.req_valid <= (state_n != IDLE);
      exc_q         <= load_op && !legal;
      if (load_op && legal) begin
        bus.req_addr     <= {bus.in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        bus.req_we       <= bus.in_we;
        bus.req_be       <= be_wide[BUS_BYTES-1:0];
        bus.req_wdata    <= wdata_wide[XLEN-1:0];
        bus.req_offset   <= bus.in_addr[2:0];
        bus.req_size     <= bus.in_size;
        bus.req_unsigned <= bus.in_unsigned;
        bus.req_tag      <= bus.in_tag;
`ifdef MISALIGN_SPLIT_EN
        bus.req_last     <= !crosses;
        be2_q            <= be_wide[2*BUS_BYTES-1:BUS_BYTES];
        wdata2_q         <= wdata_wide[2*XLEN-1:XLEN];
      end else if (load_beat2) begin
        bus.req_addr     <= bus.req_addr + ADDR_W'(BUS_BYTES);
        bus.req_be       <= be2_q;
        bus.req_wdata    <= wdata2_q;
        bus.req_last     <= 1'b1;
`else
        bus.req_last     <= 1'b1;
`endif
      end
      if (load_op && !legal) begin
        bus.exc_addr <= bus.in_addr;
        bus.exc_tag  <= bus.in_tag;
      end
    end
  end

endmodule
